axis_fifo: RTL
==============

Name: axis_fifo

Overview:
- Parameterised synchronous FIFO with AXI Stream interfaces on both sides.
- Sits directly downstream of an axis register slice. Absorbs bursts and decouples producer stalls from consumer stalls between pipeline stages of the core, e.g. fetch → decode.
- Provides flush, which drops all buffered beats on redirect, and exposes occupancy for credit or debug logic.

Parameters:
- DEPTH, 4, number of entries; power of two, ≥2.
- TDATA_WIDTH is not a module parameter. It comes from the interfaces: localparam = axis_mif.TDATA_WIDTH. An initial assert requires it to be >0 and equal to axis_sif.TDATA_WIDTH.

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  reset, asynchronous assert, active-low (0 = reset); deassertion is synchronous to clk, handled externally.
- axis_sif  interface(s)  tvalid/tready/tdata[TDATA_WIDTH]  write side; FIFO drives tready.
- axis_mif  interface(m)  tvalid/tready/tdata[TDATA_WIDTH]  read side; FIFO drives tvalid/tdata.
- flush  input  1  synchronous discard of all stored beats.
- count  output  $clog2(DEPTH+1)  current occupancy, 0..DEPTH.

Behaviour:
- **State**
  - mem[DEPTH] of TDATA_WIDTH; wr_ptr, rd_ptr each $clog2(DEPTH)+1 bits, MSB is the wrap bit.
  - empty = (wr_ptr == rd_ptr).
  - full = index bits equal and MSBs differ.
  - count = wr_ptr - rd_ptr, modulo pointer width.
- **Reset** (rst==0, asynchronous)
  - wr_ptr = rd_ptr = 0, count = 0.
  - axis_mif.tvalid = 0; axis_sif.tready = 0 while rst==0.
  - mem contents are not reset.
- **Outputs**
  - axis_sif.tready = rst && !full. Independent of axis_mif.tready: no write-through when full.
  - axis_mif.tvalid = !empty.
  - axis_mif.tdata = mem[rd_ptr index], a combinational read. It is stable while tvalid && !tready (AXIS rule).
- **Push / pop**
  - push = axis_sif.tvalid && axis_sif.tready.
  - pop = axis_mif.tvalid && axis_mif.tready.
  - On push: mem[wr idx] <= tdata, wr_ptr++.
  - On pop: rd_ptr++.
- **Latency**: a beat accepted in cycle N is visible on axis_mif in cycle N+1. There is no combinational bypass from axis_sif to axis_mif.
- **Throughput**: simultaneous push and pop in the same cycle is allowed whenever 0<count<DEPTH. Count is unchanged, giving 1 beat/cycle sustained.
- **Boundaries**
  - Empty: pop impossible; push only, count 0→1.
  - Full: push impossible; pop only, count DEPTH→DEPTH-1. tready rises the cycle after the pop.
  - Wrap-around: pointer index wraps mod DEPTH and the MSB toggles. Order is preserved across the wrap.
- **Flush** (synchronous, priority over push/pop)
  - Next edge: rd_ptr <= wr_ptr, i.e. empty, count 0.
  - A push or pop in the flush cycle is discarded and not stored. Upstream sees the handshake as completed.
  - tready is unaffected by flush in that cycle.
- **Reset mid-operation**: all beats are lost immediately. Outputs go to reset values asynchronously.
- **Checks**: no combinational path from axis_mif.tready to axis_sif.tready, or from axis_sif.tvalid to axis_mif.tvalid.

Decomposition:
- Shared package: none required. Pointer width is a localparam computed in-module.
- Natural sub-module: axis_fifo_mem, a simple dual-port array with one write port and one asynchronous read port. This keeps storage swappable for LUTRAM/BRAM mapping.
- Control logic (pointers, flags, handshake) stays in axis_fifo.

Test Plan:
1. Reset then idle, DEPTH=4 → axis_sif.tready=0 during rst==0, then 1; axis_mif.tvalid=0, count=0.
2. Push 0x11,0x22,0x33,0x44 with consumer tready=0 → count 1,2,3,4; axis_sif.tready=0 after the 4th push. A 5th beat 0x55 is held off, and tdata stays 0x11.
3. From full, consumer tready=1 for 6 cycles while producer offers 0x55,0x66 → output order 0x11,0x22,0x33,0x44,0x55,0x66. Pointers wrap; count ends 0.
4. Continuous stream of 16 beats (0..15) with both sides ready every cycle → one beat per cycle after 1-cycle latency; count steady at 1; no reordering.
5. With count=3 (0xA,0xB,0xC), assert flush while pushing 0xD → next cycle count=0, tvalid=0; 0xD never appears. A subsequent push of 0xE is output next.
6. With count=2, pull rst low asynchronously between clock edges → tvalid and count go to 0 immediately. After release, the first pushed beat is the first read.

Source files
------------

// File: rtl/axis_fifo_pkg.sv
// rtl/axis_fifo_pkg.sv - shared constants and elaboration helpers for axis_fifo
`timescale 1ns/1ps
package axis_fifo_pkg;

  localparam int AXIS_FIFO_DEFAULT_DEPTH = 4;

  function automatic bit is_pow2(input int n);
    return (n > 0) && ((n & (n - 1)) == 0);
  endfunction

endpackage

// File: rtl/axis_if.sv
// rtl/axis_if.sv - minimal AXI-Stream channel (tvalid/tready/tdata)
`timescale 1ns/1ps
interface axis_if #(
  parameter int TDATA_WIDTH = 8
);
  logic                   tvalid;
  logic                   tready;
  logic [TDATA_WIDTH-1:0] tdata;

  modport s (input tvalid, input tdata, output tready);
  modport m (output tvalid, output tdata, input tready);
endinterface

// File: rtl/axis_fifo_mem.sv
// rtl/axis_fifo_mem.sv - simple dual-port storage, one sync write port, one async read port
`timescale 1ns/1ps
module axis_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             i_we,
  input  logic [AW-1:0]    i_waddr,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic [AW-1:0]    i_raddr,
  output logic [WIDTH-1:0] o_rdata
);

  // No reset on the array so it can map onto LUTRAM/BRAM.
  logic [WIDTH-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/axis_fifo.sv
// rtl/axis_fifo.sv - AXI-Stream synchronous FIFO with flush and occupancy output
`timescale 1ns/1ps
module axis_fifo
  import axis_fifo_pkg::*;
#(
  parameter int DEPTH = AXIS_FIFO_DEFAULT_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
  axis_if.s                            axis_sif,
  axis_if.m                            axis_mif,
  input  logic                         flush,
  output logic [$clog2(DEPTH+1)-1:0]   count
);

  localparam int TDATA_WIDTH = axis_mif.TDATA_WIDTH;
  localparam int AW          = $clog2(DEPTH);
  localparam int PW          = AW + 1;
  localparam int CW          = $clog2(DEPTH + 1);

  if (!is_pow2(DEPTH) || (DEPTH < 2)) begin : g_bad_depth
    $error("axis_fifo: DEPTH must be a power of two >= 2");
  end
  if ((TDATA_WIDTH <= 0) || (TDATA_WIDTH != axis_sif.TDATA_WIDTH)) begin : g_bad_width
    $error("axis_fifo: TDATA_WIDTH must be > 0 and match on both interfaces");
  end

  logic [PW-1:0]          r_wr_ptr;
  logic [PW-1:0]          r_rd_ptr;
  logic                   w_empty;
  logic                   w_full;
  logic                   w_push;
  logic                   w_pop;
  logic [PW-1:0]          w_occ;
  logic [TDATA_WIDTH-1:0] w_rdata;

  assign w_empty = (r_wr_ptr == r_rd_ptr);
  assign w_full  = (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]) && (r_wr_ptr[AW] != r_rd_ptr[AW]);

  // tready depends only on registered state, so there is no path from downstream tready.
  assign axis_sif.tready = rst && !w_full;
  assign axis_mif.tvalid = !w_empty;
  assign axis_mif.tdata  = w_rdata;

  assign w_push = axis_sif.tvalid && axis_sif.tready;
  assign w_pop  = axis_mif.tvalid && axis_mif.tready;

  assign w_occ = r_wr_ptr - r_rd_ptr;
  assign count = CW'(w_occ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
    end else if (flush) begin
      // Handshakes in the flush cycle complete upstream but leave nothing behind.
      r_rd_ptr <= r_wr_ptr;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PW'(1);
      end
    end
  end

  axis_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (TDATA_WIDTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .i_we    (w_push && !flush),
    .i_waddr (r_wr_ptr[AW-1:0]),
    .i_wdata (axis_sif.tdata),
    .i_raddr (r_rd_ptr[AW-1:0]),
    .o_rdata (w_rdata)
  );

endmodule
